// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Laser 310 expansion Z80 bus initiator.
package z80_bus_pkg;

  // Request types, encoded exactly as they appear on req_type.
  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } req_type_e;

  // Bus cycle states; TWA is the automatic wait state of I/O cycles.
  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TWA,
    S_TW,
    S_T3,
    S_RESP
  } state_e;

  localparam logic [3:0] BANK_PORT_HI   = 4'b0111;
  localparam logic [1:0] BANK_RESET     = 2'b01;
  // A15..A11 of the banked window at B800h.
  localparam logic [4:0] BANK_AREA_BASE = 5'b10111;

  // Request type bit 1 selects I/O space, bit 0 selects a write.
  function automatic logic is_io(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic logic is_write(input logic [1:0] t);
    return t[0];
  endfunction

endpackage

// File: rtl/z80_tstate_timer.sv
// Divides clk into Z80 T-states and flags the last clk of each T-state.
module z80_tstate_timer #(
  parameter int CLK_PER_T = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_t_end
);

  localparam logic [3:0] LAST_TICK = 4'(CLK_PER_T - 1);

  logic [3:0] r_tick;
  logic       w_t_end;

  assign w_t_end = (r_tick == LAST_TICK);
  assign o_t_end = w_t_end;

  // Tick counter: held at 0 outside bus cycles, wraps at the end of each T-state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 4'd0;
    end else if (i_clear || w_t_end) begin
      r_tick <= 4'd0;
    end else begin
      r_tick <= r_tick + 4'd1;
    end
  end

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus initiator: turns single requests into T-state timed memory/I/O cycles,
// honours WAIT_N with a timeout, and mirrors the expansion bank latch.
module z80_bus_master #(
  parameter int         CLK_PER_T    = 2,
  parameter int         MAX_WAIT     = 255,
  parameter logic [3:0] BANK_PORT_HI = 4'b0111,
  parameter logic [1:0] BANK_RESET   = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] ADDR,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic [7:0]  D_IN,
  output logic        MREQ_N,
  output logic        IORQ_N,
  output logic        RD_N,
  output logic        WR_N,
  input  logic        WAIT_N,
  output logic [1:0]  bank_shadow
);

  import z80_bus_pkg::*;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_e      r_state;
  logic [1:0]  r_type;
  logic [15:0] r_addr;
  logic [7:0]  r_dout;
  logic        r_doe;
  logic        r_mreq_n;
  logic        r_iorq_n;
  logic        r_rd_n;
  logic        r_wr_n;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [7:0]  r_rdata;
  logic [1:0]  r_bank;
  logic [7:0]  r_wait_cnt;
  logic        w_t_end;
  logic        w_timer_clear;

  // The timer only runs while a bus cycle is in its T-states.
  assign w_timer_clear = (r_state == S_IDLE) || (r_state == S_RESP);

  z80_tstate_timer #(
    .CLK_PER_T(CLK_PER_T)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_timer_clear),
    .o_t_end(w_t_end)
  );

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rdata;
  assign ADDR        = r_addr;
  assign D_OUT       = r_dout;
  assign D_OE        = r_doe;
  assign MREQ_N      = r_mreq_n;
  assign IORQ_N      = r_iorq_n;
  assign RD_N        = r_rd_n;
  assign WR_N        = r_wr_n;
  assign bank_shadow = r_bank;

  // Bus cycle FSM; every bus output is registered on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_type      <= 2'b00;
      r_addr      <= 16'h0000;
      r_dout      <= 8'h00;
      r_doe       <= 1'b0;
      r_mreq_n    <= 1'b1;
      r_iorq_n    <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 8'h00;
      r_bank      <= BANK_RESET;
      r_wait_cnt  <= 8'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_type     <= req_type;
            r_addr     <= req_addr;
            r_dout     <= req_wdata;
            r_doe      <= is_write(req_type);
            r_wait_cnt <= 8'd0;
            r_state    <= S_T1;
          end
        end
        S_T1: begin
          if (w_t_end) begin
            r_mreq_n <= is_io(r_type);
            r_iorq_n <= !is_io(r_type);
            r_rd_n   <= is_write(r_type);
            r_wr_n   <= !is_write(r_type);
            r_state  <= S_T2;
          end
        end
        S_T2: begin
          if (w_t_end) begin
            if (is_io(r_type)) begin
              r_state <= S_TWA;
            end else if (!WAIT_N) begin
              r_wait_cnt <= 8'd1;
              r_state    <= S_TW;
            end else begin
              r_state <= S_T3;
            end
          end
        end
        S_TWA: begin
          if (w_t_end) begin
            if (!WAIT_N) begin
              r_wait_cnt <= 8'd1;
              r_state    <= S_TW;
            end else begin
              r_state <= S_T3;
            end
          end
        end
        S_TW: begin
          if (w_t_end) begin
            if (WAIT_N) begin
              r_state <= S_T3;
            end else if (r_wait_cnt >= WAIT_LIMIT) begin
              // Target never released the bus: abort with an error response.
              r_mreq_n    <= 1'b1;
              r_iorq_n    <= 1'b1;
              r_rd_n      <= 1'b1;
              r_wr_n      <= 1'b1;
              r_doe       <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
        end
        S_T3: begin
          if (w_t_end) begin
            if (!is_write(r_type)) begin
              r_rdata <= D_IN;
            end
            if (is_io(r_type) && is_write(r_type) && (r_addr[7:4] == BANK_PORT_HI)) begin
              r_bank <= r_dout[1:0];
            end
            r_mreq_n    <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_doe       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master with a cycle-offset reference model.
module tb_z80_bus_master;

  localparam int CPT  = 2;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'b00;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] ADDR;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN = 8'h00;
  logic        MREQ_N;
  logic        IORQ_N;
  logic        RD_N;
  logic        WR_N;
  logic        WAIT_N = 1'b1;
  logic [1:0]  bank_shadow;

  z80_bus_master #(
    .CLK_PER_T   (CPT),
    .MAX_WAIT    (MAXW),
    .BANK_PORT_HI(4'b0111),
    .BANK_RESET  (2'b01)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ADDR       (ADDR),
    .D_OUT      (D_OUT),
    .D_OE       (D_OE),
    .D_IN       (D_IN),
    .MREQ_N     (MREQ_N),
    .IORQ_N     (IORQ_N),
    .RD_N       (RD_N),
    .WR_N       (WR_N),
    .WAIT_N     (WAIT_N),
    .bank_shadow(bank_shadow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction currently being modelled.
  bit          tx_on = 0;
  bit          tx_done = 0;
  int          tx_k = 0;
  logic [1:0]  tx_type;
  logic [15:0] tx_addr;
  logic [7:0]  tx_wdata;
  logic [7:0]  tx_din;
  int          tx_nwait;
  bit          tx_to;
  logic [1:0]  exp_bank = 2'b01;
  logic [7:0]  exp_rdata = 8'h00;
  int          cnt_mreq, cnt_iorq, cnt_rd, cnt_wr, cnt_oe, rsp_k;

  // Reference model: T-state index = (k-1)/CPT, where k counts clks after the accept clk.
  // T-states are T1, T2, [TWA], nwait x TW, [T3 unless timed out]; RESP is the clk after.
  always @(negedge clk) begin : cmp
    int k, nt, last, idx;
    bit io, wr, in_t, strobe, resp;
    if (tx_on) begin
      k    = tx_k;
      io   = tx_type[1];
      wr   = tx_type[0];
      nt   = 2 + (io ? 1 : 0) + tx_nwait + (tx_to ? 0 : 1);
      last = nt * CPT;
      if (k == 0) begin
        chk("accept_ready", req_ready, 1);
      end else if (k <= last + 1) begin
        in_t   = (k <= last);
        idx    = (k - 1) / CPT;
        strobe = in_t && (idx >= 1);
        resp   = (k == last + 1);
        chk("MREQ_N", MREQ_N, !(strobe && !io));
        chk("IORQ_N", IORQ_N, !(strobe && io));
        chk("RD_N", RD_N, !(strobe && !wr));
        chk("WR_N", WR_N, !(strobe && wr));
        chk("D_OE", D_OE, in_t && wr);
        if (in_t) chk("ADDR", ADDR, tx_addr);
        if (in_t && wr) chk("D_OUT", D_OUT, tx_wdata);
        chk("busy_ready", req_ready, 0);
        if (resp) begin
          if (!wr && !tx_to) exp_rdata = tx_din;
          if (io && wr && !tx_to && tx_addr[7:4] == 4'h7) exp_bank = tx_wdata[1:0];
          rsp_k = k;
          chk("rsp_valid", rsp_valid, 1);
          chk("rsp_err", rsp_err, tx_to);
          chk("rsp_rdata", rsp_rdata, exp_rdata);
        end else begin
          chk("rsp_idle", rsp_valid, 0);
        end
        if (!MREQ_N) cnt_mreq++;
        if (!IORQ_N) cnt_iorq++;
        if (!RD_N) cnt_rd++;
        if (!WR_N) cnt_wr++;
        if (D_OE) cnt_oe++;
      end else begin
        chk("ready_after", req_ready, 1);
        chk("strobes_after", {MREQ_N, IORQ_N, RD_N, WR_N}, 4'hF);
        chk("rsp_after", rsp_valid, 0);
        tx_done = 1;
        tx_on   = 0;
      end
      chk("bank_shadow", bank_shadow, exp_bank);
      tx_k = k + 1;
    end
  end

  task automatic run_tx(input logic [1:0] t, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int nwait, input bit to);
    int io;
    io = t[1] ? 1 : 0;
    @(posedge clk); #1;
    tx_type = t; tx_addr = a; tx_wdata = wd; tx_din = din; tx_nwait = nwait; tx_to = to;
    cnt_mreq = 0; cnt_iorq = 0; cnt_rd = 0; cnt_wr = 0; cnt_oe = 0; rsp_k = -1;
    tx_done = 0; tx_k = 0; tx_on = 1;
    req_type = t; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    D_IN = din; WAIT_N = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~wd;
        req_type  = ~t;
      end
      if (to) WAIT_N = 1'b0;
      else if (nwait > 0 && j <= (1 + io + nwait) * CPT) WAIT_N = 1'b0;
      else WAIT_N = 1'b1;
      if (tx_done) break;
    end
    if (!tx_done) begin
      chk("tx_cycle_budget", 0, 1);
      tx_on = 0;
    end
    WAIT_N = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {MREQ_N, IORQ_N, RD_N, WR_N}, 4'hF);
    chk("rst_doe", D_OE, 0);
    chk("rst_addr", ADDR, 16'h0000);
    chk("rst_dout", D_OUT, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_bank", bank_shadow, 2'b01);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;

    // Memory write to B800h
    run_tx(2'b01, 16'hB800, 8'h55, 8'h00, 0, 0);
    chk("memwr_mreq_clks", cnt_mreq, 4);
    chk("memwr_wr_clks", cnt_wr, 4);
    chk("memwr_oe_clks", cnt_oe, 6);
    chk("memwr_latency", rsp_k, 7);

    // Memory read of C000h
    run_tx(2'b00, 16'hC000, 8'h00, 8'hA5, 0, 0);
    chk("memrd_rd_clks", cnt_rd, 4);
    chk("memrd_iorq_clks", cnt_iorq, 0);
    chk("memrd_latency", rsp_k, 7);
    chk("memrd_rdata", rsp_rdata, 8'hA5);

    // Bank port write, then a write to a neighbouring port
    run_tx(2'b11, 16'h0070, 8'h02, 8'h00, 0, 0);
    chk("iowr_iorq_clks", cnt_iorq, 6);
    chk("iowr_wr_clks", cnt_wr, 6);
    chk("iowr_oe_clks", cnt_oe, 8);
    chk("iowr_latency", rsp_k, 9);
    chk("iowr_bank", bank_shadow, 2'b10);
    run_tx(2'b11, 16'h0060, 8'h03, 8'h00, 0, 0);
    chk("iowr_other_bank", bank_shadow, 2'b10);

    // I/O read
    run_tx(2'b10, 16'h0071, 8'h00, 8'h3C, 0, 0);
    chk("iord_latency", rsp_k, 9);
    chk("iord_rdata", rsp_rdata, 8'h3C);

    // Memory read stretched by three wait states
    run_tx(2'b00, 16'h1234, 8'h00, 8'h5A, 3, 0);
    chk("wait3_latency", rsp_k, 13);
    chk("wait3_rdata", rsp_rdata, 8'h5A);

    // Wait timeout on a memory read and on a bank port write
    run_tx(2'b00, 16'h2000, 8'h00, 8'hFF, MAXW, 1);
    chk("to_latency", rsp_k, 13);
    chk("to_rdata_held", rsp_rdata, 8'h5A);
    run_tx(2'b11, 16'h0070, 8'h01, 8'h00, MAXW, 1);
    chk("to_io_latency", rsp_k, 15);
    chk("to_io_bank", bank_shadow, 2'b10);

    // Reset in T2 of a bank port write
    @(posedge clk); #1;
    req_type = 2'b11; req_addr = 16'h0070; req_wdata = 8'h02; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_in_t2", IORQ_N, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {MREQ_N, IORQ_N, RD_N, WR_N}, 4'hF);
    chk("abort_doe", D_OE, 0);
    chk("abort_bank", bank_shadow, 2'b01);
    chk("abort_rsp", rsp_valid, 0);
    exp_bank = 2'b01;
    exp_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_ready", req_ready, 1);

    // Normal operation after the abort
    run_tx(2'b00, 16'hB801, 8'h00, 8'hC3, 0, 0);
    chk("post_rst_rdata", rsp_rdata, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
